// File: rtl/multiplier_datapath.sv
// multiplier_datapath
//   Register/arithmetic datapath for the signed add-shift multiplier.
//   Holds the sign-extension bit X, accumulator A, multiplier/product-low
//   register B, a WIDTH+1-bit adder/subtractor and the iteration counter.
//   The final signed product is A:B, with X as its sign copy.
//
// Ports:
//   Clk       in   system clock, rising-edge state updates
//   Reset     in   synchronous, active-high reset (clears all state)
//   S         in   multiplicand switches, also the B load value
//   LD_B      in   load B from S
//   Clr_XA    in   clear X, A and count
//   LD_XA     in   load adder result into X:A
//   SUB_ADD   in   0 = A+S, 1 = A-S
//   Shift_EN  in   arithmetic shift right of X:A:B
//   Cnt_EN    in   increment iteration counter
//   Aval      out  register A (product high half)
//   Bval      out  register B (product low half)
//   X         out  sign-extension bit
//   M         out  current multiplier bit, B[0]
//   count     out  iteration counter, clog2(WIDTH) bits
module multiplier_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           S,
  input  logic                       LD_B,
  input  logic                       Clr_XA,
  input  logic                       LD_XA,
  input  logic                       SUB_ADD,
  input  logic                       Shift_EN,
  input  logic                       Cnt_EN,
  output logic [WIDTH-1:0]           Aval,
  output logic [WIDTH-1:0]           Bval,
  output logic                       X,
  output logic                       M,
  output logic [$clog2(WIDTH)-1:0]   count
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [WIDTH:0] operand;
  logic [WIDTH:0] sum;

  // Subtraction as A + ~S + 1 on sign-extended operands, wrapping at WIDTH+1 bits.
  always_comb begin
    operand = {S[WIDTH-1], S} ^ {(WIDTH+1){SUB_ADD}};
    sum     = {Aval[WIDTH-1], Aval} + operand + {{WIDTH{1'b0}}, SUB_ADD};
  end

  assign M = Bval[0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      X     <= 1'b0;
      Aval  <= '0;
      Bval  <= '0;
      count <= '0;
    end else begin
      // Shift takes precedence over LD_XA so a combined strobe is a pure shift.
      if (Clr_XA) begin
        X    <= 1'b0;
        Aval <= '0;
      end else if (Shift_EN) begin
        Aval <= {X, Aval[WIDTH-1:1]};
      end else if (LD_XA) begin
        {X, Aval} <= sum;
      end

      // B takes the pre-shift A[0].
      if (LD_B) begin
        Bval <= S;
      end else if (Shift_EN) begin
        Bval <= {Aval[0], Bval[WIDTH-1:1]};
      end

      if (Clr_XA) begin
        count <= '0;
      end else if (Cnt_EN) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb_multiplier_datapath
//   Self-checking bench for multiplier_datapath: a table of single-cycle
//   strobe vectors with hand-derived expected register states, plus full
//   multiply sequences checked against a signed-product model. Expected
//   states are queued when stimulus is driven and popped when sampled.
module tb_multiplier_datapath;

  logic       Clk;
  logic       Reset;
  logic [7:0] S;
  logic       LD_B, Clr_XA, LD_XA, SUB_ADD, Shift_EN, Cnt_EN;
  logic [7:0] Aval, Bval;
  logic       X, M;
  logic [2:0] count;

  multiplier_datapath #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .S        (S),
    .LD_B     (LD_B),
    .Clr_XA   (Clr_XA),
    .LD_XA    (LD_XA),
    .SUB_ADD  (SUB_ADD),
    .Shift_EN (Shift_EN),
    .Cnt_EN   (Cnt_EN),
    .Aval     (Aval),
    .Bval     (Bval),
    .X        (X),
    .M        (M),
    .count    (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst, ldb, clr, ldxa, sub, sh, cnt;
    logic [7:0] s;
    logic       ex;
    logic [7:0] ea, eb;
    logic [2:0] ec;
  } vec_t;

  typedef struct {
    string      name;
    logic       x;
    logic [7:0] a, b;
    logic [2:0] c;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".X"},     {15'd0, X},     {15'd0, e.x});
      chk({e.name, ".A"},     {8'd0, Aval},   {8'd0, e.a});
      chk({e.name, ".B"},     {8'd0, Bval},   {8'd0, e.b});
      chk({e.name, ".count"}, {13'd0, count}, {13'd0, e.c});
      chk({e.name, ".M"},     {15'd0, M},     {15'd0, e.b[0]});
    end
  endtask

  task automatic drive(input logic rst, ldb, clr, ldxa, sub, sh, cnt, input logic [7:0] s);
    Reset = rst; LD_B = ldb; Clr_XA = clr; LD_XA = ldxa;
    SUB_ADD = sub; Shift_EN = sh; Cnt_EN = cnt; S = s;
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic v(input string name, input logic rst, ldb, clr, ldxa, sub, sh, cnt,
                   input logic [7:0] s, input logic ex, input logic [7:0] ea, eb,
                   input logic [2:0] ec);
    vec_t t;
    t.name = name; t.rst = rst; t.ldb = ldb; t.clr = clr; t.ldxa = ldxa;
    t.sub = sub; t.sh = sh; t.cnt = cnt; t.s = s;
    t.ex = ex; t.ea = ea; t.eb = eb; t.ec = ec;
    tbl.push_back(t);
  endtask

  task automatic run_vec(input vec_t t);
    exp_t e;
    drive(t.rst, t.ldb, t.clr, t.ldxa, t.sub, t.sh, t.cnt, t.s);
    e.name = t.name; e.x = t.ex; e.a = t.ea; e.b = t.eb; e.c = t.ec;
    sb.push_back(e);
    cycle();
    compare_out();
  endtask

  // Drives the control-FSM strobe sequence: add (subtract on the last bit)
  // when M=1, then shift and count, for 8 iterations.
  task automatic mult(input string name, input logic [7:0] b, input logic [7:0] s);
    exp_t        e;
    logic [15:0] prod;
    prod   = 16'($signed(b) * $signed(s));
    e.name = name; e.x = prod[15]; e.a = prod[15:8]; e.b = prod[7:0]; e.c = 3'd0;
    sb.push_back(e);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
    cycle();
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, M, (i == 7), 1'b0, 1'b0, s);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    //  name          rst ldb clr ldxa sub sh cnt  S      X     A      B      count
    v("reset_all",    1, 1, 1, 1, 1, 1, 1, 8'hFF, 1'b0, 8'h00, 8'h00, 3'd0);
    v("ldb_03",       0, 1, 0, 0, 0, 0, 0, 8'h03, 1'b0, 8'h00, 8'h03, 3'd0);
    v("clr_xa",       0, 0, 1, 0, 0, 0, 0, 8'h00, 1'b0, 8'h00, 8'h03, 3'd0);
    v("add_7f",       0, 0, 0, 1, 0, 0, 0, 8'h7F, 1'b0, 8'h7F, 8'h03, 3'd0);
    v("add_ovf",      0, 0, 0, 1, 0, 0, 0, 8'h01, 1'b0, 8'h80, 8'h03, 3'd0);
    v("clr2",         0, 0, 1, 0, 0, 0, 0, 8'h00, 1'b0, 8'h00, 8'h03, 3'd0);
    v("sub_01",       0, 0, 0, 1, 1, 0, 0, 8'h01, 1'b1, 8'hFF, 8'h03, 3'd0);
    v("clr3",         0, 0, 1, 0, 0, 0, 0, 8'h00, 1'b0, 8'h00, 8'h03, 3'd0);
    v("add_80",       0, 0, 0, 1, 0, 0, 0, 8'h80, 1'b1, 8'h80, 8'h03, 3'd0);
    v("clr4",         0, 0, 1, 0, 0, 0, 0, 8'h00, 1'b0, 8'h00, 8'h03, 3'd0);
    v("add_81",       0, 0, 0, 1, 0, 0, 0, 8'h81, 1'b1, 8'h81, 8'h03, 3'd0);
    v("ldb_02",       0, 1, 0, 0, 0, 0, 0, 8'h02, 1'b1, 8'h81, 8'h02, 3'd0);
    v("shift",        0, 0, 0, 0, 0, 1, 0, 8'h00, 1'b1, 8'hC0, 8'h81, 3'd0);
    v("ldxa_shift",   0, 0, 0, 1, 1, 1, 0, 8'h55, 1'b1, 8'hE0, 8'h40, 3'd0);
    v("hold",         0, 0, 0, 0, 0, 0, 0, 8'hAA, 1'b1, 8'hE0, 8'h40, 3'd0);
    v("ldb_shift",    0, 1, 0, 0, 0, 1, 0, 8'h33, 1'b1, 8'hF0, 8'h33, 3'd0);
    v("clr5",         0, 0, 1, 0, 0, 0, 0, 8'h00, 1'b0, 8'h00, 8'h33, 3'd0);
    for (int unsigned i = 1; i <= 8; i++)
      v($sformatf("cnt_%0d", i), 0, 0, 0, 0, 0, 0, 1, 8'h00, 1'b0, 8'h00, 8'h33, 3'(i));
    v("cnt_again",    0, 0, 0, 0, 0, 0, 1, 8'h00, 1'b0, 8'h00, 8'h33, 3'd1);
    v("clr_cnt",      0, 0, 1, 0, 0, 0, 1, 8'h00, 1'b0, 8'h00, 8'h33, 3'd0);
    v("cnt_shift",    0, 0, 0, 0, 0, 1, 1, 8'h00, 1'b0, 8'h00, 8'h19, 3'd1);
    v("clr_shift",    0, 0, 1, 0, 0, 1, 0, 8'h00, 1'b0, 8'h00, 8'h0C, 3'd0);
    v("add_pre_rst",  0, 0, 0, 1, 0, 0, 1, 8'h7F, 1'b0, 8'h7F, 8'h0C, 3'd1);
    v("reset_mid",    1, 1, 0, 1, 0, 1, 1, 8'h55, 1'b0, 8'h00, 8'h00, 3'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    mult("mul_03x07", 8'h03, 8'h07);
    mult("mul_03xF9", 8'h03, 8'hF9);
    mult("mul_FDx07", 8'hFD, 8'h07);
    mult("mul_80x80", 8'h80, 8'h80);
    mult("mul_7Fx81", 8'h7F, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
Register/arithmetic datapath for the 8-bit signed add-shift multiplier. It sits directly downstream of the multiplier control FSM, consumes its LD_XA, LD_B, Shift_EN, Cnt_EN, Clr_XA and SUB_ADD strobes, and returns M and count to it. It holds the sign-extension bit X, the accumulator A, the multiplier/product-low register B, and the 9-bit adder/subtractor and iteration counter. The final 16-bit signed product is A:B, with X as the sign copy.

Parameters:
WIDTH, 8, operand width of S, A and B. count width is clog2(WIDTH); the adder is WIDTH+1 bits.

Ports:
Clk  in  1  system clock, all state updates on its rising edge
Reset  in  1  synchronous, active-high reset
S  in  WIDTH  multiplicand switches (also the B load value)
LD_B  in  1  load B from S
Clr_XA  in  1  clear X, A and count
LD_XA  in  1  load adder result into X:A
SUB_ADD  in  1  0 = A+S, 1 = A-S
Shift_EN  in  1  arithmetic shift right of X:A:B
Cnt_EN  in  1  increment iteration counter
Aval  out  WIDTH  register A (product high byte)
Bval  out  WIDTH  register B (product low byte)
X  out  1  sign-extension bit
M  out  1  current multiplier bit, equals B[0] combinationally
count  out  3  iteration counter

Behaviour:
- One clock; reset is synchronous and active-high: Clk, Reset. Reset sampled high on a rising edge sets X=0, A=0, B=0 and count=0, so M=0. Reset overrides all strobes.
- Adder, combinational: sum[8:0] = {A[7],A} + ({S[7],S} XOR {9{SUB_ADD}}) + SUB_ADD, computed as two's-complement with 9-bit wrap. X:A priority each cycle is Clr_XA > Shift_EN > LD_XA > hold.
  - Clr_XA: X=0, A=0.
  - Shift_EN: X keeps its value, A = {X, A[7:1]}.
  - LD_XA alone: X = sum[8], A = sum[7:0].
  - LD_XA with Shift_EN, as the FSM issues in FirstShift: the shift wins and no add occurs.
- B priority: LD_B > Shift_EN > hold.
  - LD_B: B = S.
  - Shift_EN: B = {A[0], B[7:1]}, using the pre-shift A[0].
- count priority: Clr_XA > Cnt_EN > hold.
  - Clr_XA: count = 0.
  - Cnt_EN: count = count+1, mod 8, so 7 wraps to 0.
  - Cnt_EN is independent of Shift_EN.
- All register updates take effect one cycle after the strobe is sampled. Outputs are direct register values with no extra latency.
- M = B[0] with no register, so the FSM sees the new bit in the cycle after a shift.
- Reset mid-operation: all state returns to zero on that edge and the partial product is lost.
- Strobe sets not produced by the FSM resolve by the priorities above, with no X-propagation.
- A full multiply of 8 shifts yields a signed 16-bit product in A:B, with X = A[7].

Test Plan:
1. Reset asserted with all strobes high -> next cycle X=0, A=0x00, B=0x00, count=0, M=0.
2. LD_B with S=0x03, then Clr_XA -> B=0x03, M=1, A=0x00, X=0, count=0.
3. Adder boundaries, each case with A cleared first:
   - A=0x7F (load via S=0x7F add), then S=0x01 add -> X=0, A=0x80.
   - From A=0x00, S=0x01 with SUB_ADD=1 -> X=1, A=0xFF.
   - From A=0x00, S=0x80 add -> X=1, A=0x80.
4. Shift: X=1, A=0x81, B=0x02, then Shift_EN -> X=1, A=0xC0, B=0x81, M=1. Assert LD_XA+Shift_EN together -> the result equals a pure shift.
5. Counter: 8 Cnt_EN pulses from 0 -> count passes 1..7 then returns to 0. Clr_XA with Cnt_EN -> count=0.
6. Full multiply, with the bench driving the FSM strobe sequence (add when M=1, subtract on the 8th bit when M=1, shift each iteration):
   - B=0x03, S=0x07 -> A:B=0x0015, X=0.
   - B=0x03, S=0xF9 -> A:B=0xFFEB, X=1.
   - B=0xFD, S=0x07 -> A:B=0xFFEB, X=1.
   - B=0x80, S=0x80 -> A:B=0x4000, X=0.
